// File: rtl/call_frame_ctrl.sv
// call_frame_ctrl
//   Call-frame manager for the WASM core. It drives the control-stack side of
//   the operand stack. On a call it pushes {caller frame_base, return PC} and
//   tells the operand stack to allocate the callee locals. On a return it pops
//   the record, truncates the operand stack back to the callee frame base and
//   returns the PC to fetch. Every operation spends one EXEC cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   call_req, ret_req   requests; sampled in IDLE only
//   param_num           callee parameter count (already on the operand stack)
//   local_num           extra callee locals to allocate
//   ret_pc_in           PC to resume at after the matching return
//   os_top_pointer      current operand stack top
//   err_clr             clears the sticky error flags
//   busy                high in EXEC
//   done                1-cycle pulse when a call/return commits
//   os_shift_vld        operand stack shift_vld
//   os_call, os_retu    operand stack call / return strobes
//   os_alloc_size       allocate_local_memory_size
//   os_tag              control_stack_tag (top pointer to restore on return)
//   ret_pc_out          last popped return PC
//   ret_pc_vld          pulse with a committed return
//   frame_base          local-0 index of the current frame
//   frame_depth         number of live frame records
//   err_overflow, err_underflow, err_param   sticky error flags
module call_frame_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int PC_W    = 16,
  parameter int FD_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               call_req,
  input  logic               ret_req,
  input  logic [7:0]         param_num,
  input  logic [7:0]         local_num,
  input  logic [PC_W-1:0]    ret_pc_in,
  input  logic [ADDR_W:0]    os_top_pointer,
  input  logic               err_clr,
  output logic               busy,
  output logic               done,
  output logic               os_shift_vld,
  output logic               os_call,
  output logic               os_retu,
  output logic [7:0]         os_alloc_size,
  output logic [ADDR_W-1:0]  os_tag,
  output logic [PC_W-1:0]    ret_pc_out,
  output logic               ret_pc_vld,
  output logic [ADDR_W-1:0]  frame_base,
  output logic [FD_LOG2:0]   frame_depth,
  output logic               err_overflow,
  output logic               err_underflow,
  output logic               err_param
);

  localparam int FRAMES = 2 ** FD_LOG2;
  localparam int CW     = ADDR_W + 9;
  localparam logic [FD_LOG2:0] DEPTH_ONE  = (FD_LOG2+1)'(1);
  localparam logic [FD_LOG2:0] DEPTH_FULL = (FD_LOG2+1)'(FRAMES);
  localparam logic [CW-1:0]    OS_CAP     = CW'(1) << ADDR_W;

  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_nxt;

  // Request checks, evaluated on the raw inputs in IDLE
  logic              req;
  logic [CW-1:0]     top_w, param_w, local_w, diff_w, alloc_end;
  logic [ADDR_W-1:0] new_base;
  logic              chk_param, chk_ovf, chk_und, chk_any;

  assign req       = call_req | ret_req;
  assign top_w     = CW'(os_top_pointer);
  assign param_w   = CW'(param_num);
  assign local_w   = CW'(local_num);
  assign diff_w    = top_w - param_w;
  assign new_base  = diff_w[ADDR_W-1:0];
  assign alloc_end = CW'(new_base) + param_w + local_w;
  assign chk_param = (call_req & ret_req) | (call_req & (param_w > top_w));
  assign chk_ovf   = call_req & ~ret_req & ~chk_param &
                     ((frame_depth == DEPTH_FULL) | (alloc_end > OS_CAP));
  assign chk_und   = ret_req & ~call_req & (frame_depth == '0);
  assign chk_any   = chk_param | chk_ovf | chk_und;

  // Operation latched on entry to EXEC
  logic              op_call_q, op_ret_q, op_err_q;
  logic [ADDR_W-1:0] new_base_q;
  logic [7:0]        local_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   ret_pc_q;

  // Frame record store; not reset
  logic [ADDR_W+PC_W-1:0] mem [FRAMES];
  logic [ADDR_W+PC_W-1:0] rd_q;
  logic [FD_LOG2-1:0]     wr_idx, rd_idx;
  logic                   commit_call, commit_ret;
  logic [ADDR_W-1:0]      rd_base;
  logic [PC_W-1:0]        rd_pc;

  assign wr_idx      = frame_depth[FD_LOG2-1:0];
  assign rd_idx      = FD_LOG2'(frame_depth - DEPTH_ONE);
  assign commit_call = (state == EXEC) & op_call_q & ~op_err_q;
  assign commit_ret  = (state == EXEC) & op_ret_q & ~op_err_q;
  assign rd_base     = rd_q[ADDR_W+PC_W-1:PC_W];
  assign rd_pc       = rd_q[PC_W-1:0];

  // The top record is read every cycle; the address is stable through the
  // IDLE cycle preceding EXEC, so rd_q is the popped record during EXEC.
  always_ff @(posedge clk) begin
    if (commit_call) mem[wr_idx] <= {frame_base, pc_q};
    rd_q <= mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_call_q     <= 1'b0;
      op_ret_q      <= 1'b0;
      op_err_q      <= 1'b0;
      new_base_q    <= '0;
      local_q       <= '0;
      pc_q          <= '0;
      ret_pc_q      <= '0;
      frame_base    <= '0;
      frame_depth   <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_param     <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        op_call_q  <= call_req & ~ret_req;
        op_ret_q   <= ret_req & ~call_req;
        op_err_q   <= chk_any;
        new_base_q <= new_base;
        local_q    <= local_num;
        pc_q       <= ret_pc_in;
      end
      if (commit_call) begin
        frame_depth <= frame_depth + DEPTH_ONE;
        frame_base  <= new_base_q;
      end
      if (commit_ret) begin
        frame_depth <= frame_depth - DEPTH_ONE;
        frame_base  <= rd_base;
        ret_pc_q    <= rd_pc;
      end
      // A new error in the same cycle as err_clr stays set
      err_overflow  <= (err_overflow  & ~err_clr) | ((state == IDLE) & chk_ovf);
      err_underflow <= (err_underflow & ~err_clr) | ((state == IDLE) & chk_und);
      err_param     <= (err_param     & ~err_clr) | ((state == IDLE) & chk_param);
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    os_shift_vld  = 1'b0;
    os_call       = 1'b0;
    os_retu       = 1'b0;
    os_alloc_size = '0;
    os_tag        = '0;
    ret_pc_out    = ret_pc_q;
    ret_pc_vld    = 1'b0;
    case (state)
      IDLE: if (req) state_nxt = EXEC;
      EXEC: begin
        state_nxt = IDLE;
        busy      = 1'b1;
        if (!op_err_q) begin
          done = 1'b1;
          if (op_call_q) begin
            os_call       = 1'b1;
            os_shift_vld  = 1'b1;
            os_alloc_size = local_q;
          end
          if (op_ret_q) begin
            os_retu      = 1'b1;
            os_shift_vld = 1'b1;
            os_tag       = frame_base;
            ret_pc_out   = rd_pc;
            ret_pc_vld   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_call_frame_ctrl.sv
module tb_call_frame_ctrl;

  localparam int ADDR_W  = 8;
  localparam int PC_W    = 16;
  localparam int FD_LOG2 = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               call_req, ret_req, err_clr;
  logic [7:0]         param_num, local_num;
  logic [PC_W-1:0]    ret_pc_in;
  logic [ADDR_W:0]    os_top_pointer;
  logic               busy, done, os_shift_vld, os_call, os_retu;
  logic [7:0]         os_alloc_size;
  logic [ADDR_W-1:0]  os_tag;
  logic [PC_W-1:0]    ret_pc_out;
  logic               ret_pc_vld;
  logic [ADDR_W-1:0]  frame_base;
  logic [FD_LOG2:0]   frame_depth;
  logic               err_overflow, err_underflow, err_param;

  call_frame_ctrl #(.ADDR_W(ADDR_W), .PC_W(PC_W), .FD_LOG2(FD_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .call_req(call_req), .ret_req(ret_req),
    .param_num(param_num), .local_num(local_num), .ret_pc_in(ret_pc_in),
    .os_top_pointer(os_top_pointer), .err_clr(err_clr), .busy(busy),
    .done(done), .os_shift_vld(os_shift_vld), .os_call(os_call),
    .os_retu(os_retu), .os_alloc_size(os_alloc_size), .os_tag(os_tag),
    .ret_pc_out(ret_pc_out), .ret_pc_vld(ret_pc_vld), .frame_base(frame_base),
    .frame_depth(frame_depth), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_param(err_param)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit        is_call;
    bit        is_ret;
    bit        err;
    int        alloc;
    int        tag;
    int        pc;
    int        base_after;
    int        depth_after;
    bit        ovf, und, par;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int m_base = 0;
  int m_depth = 0;
  int m_last_pc = 0;
  bit m_ovf = 0, m_und = 0, m_par = 0;
  int stk_base[$];
  int stk_pc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_base = 0; m_depth = 0; m_last_pc = 0;
    m_ovf = 0; m_und = 0; m_par = 0;
    stk_base.delete(); stk_pc.delete();
  endtask

  // Drives one request from an IDLE cycle (caller is #1 after a posedge),
  // checks the EXEC cycle against the scoreboard, then the following IDLE.
  task automatic issue(input bit c, input bit r, input int p, input int l,
                       input int pc, input int top, input bit clr);
    exp_t e;
    int   nb, n;
    bit   np, no, nu;
    e = '{default: 0};
    np = (c && r) || (c && p > top);
    no = 0;
    nu = 0;
    nb = (top - p) & 8'hFF;
    if (c && !r && !np) no = (m_depth == 16) || (nb + p + l > 256);
    if (r && !c) nu = (m_depth == 0);
    e.err = np || no || nu;
    e.is_call = c && !r;
    e.is_ret  = r && !c;
    if (!e.err && e.is_call) begin
      e.alloc = l;
      stk_base.push_back(m_base);
      stk_pc.push_back(pc);
      m_base = nb;
      m_depth++;
    end else if (!e.err && e.is_ret) begin
      e.tag = m_base;
      e.pc  = stk_pc.pop_back();
      m_base = stk_base.pop_back();
      m_last_pc = e.pc;
      m_depth--;
    end
    if (clr) begin m_ovf = 0; m_und = 0; m_par = 0; end
    m_ovf |= no; m_und |= nu; m_par |= np;
    e.ovf = m_ovf; e.und = m_und; e.par = m_par;
    e.base_after = m_base;
    e.depth_after = m_depth;
    sb.push_back(e);

    call_req = c; ret_req = r; param_num = 8'(p); local_num = 8'(l);
    ret_pc_in = 16'(pc); os_top_pointer = 9'(top); err_clr = clr;
    @(posedge clk); #1;
    call_req = 0; ret_req = 0; err_clr = 0;
    n = 0;
    while (busy !== 1'b1 && n < 4) begin @(posedge clk); #1; n++; end
    chk("busy", 32'(busy), 1);
    e = sb.pop_front();
    chk("done",      32'(done),         32'(!e.err));
    chk("os_call",   32'(os_call),      32'(!e.err && e.is_call));
    chk("os_retu",   32'(os_retu),      32'(!e.err && e.is_ret));
    chk("shift_vld", 32'(os_shift_vld), 32'(!e.err));
    chk("alloc",     32'(os_alloc_size), 32'(e.alloc));
    chk("tag",       32'(os_tag),       32'(e.tag));
    chk("pc_vld",    32'(ret_pc_vld),   32'(!e.err && e.is_ret));
    if (!e.err && e.is_ret) chk("ret_pc", 32'(ret_pc_out), 32'(e.pc));
    chk("err_ovf",   32'(err_overflow),  32'(e.ovf));
    chk("err_und",   32'(err_underflow), 32'(e.und));
    chk("err_par",   32'(err_param),     32'(e.par));
    @(posedge clk); #1;
    chk("busy_idle",   32'(busy),        0);
    chk("frame_base",  32'(frame_base),  32'(e.base_after));
    chk("frame_depth", 32'(frame_depth), 32'(e.depth_after));
    chk("pc_vld_idle", 32'(ret_pc_vld),  0);
    chk("pc_hold",     32'(ret_pc_out),  32'(m_last_pc));
  endtask

  initial begin
    rst_n = 0; call_req = 0; ret_req = 0; err_clr = 0;
    param_num = 0; local_num = 0; ret_pc_in = 0; os_top_pointer = 0;
    #12;
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_base",  32'(frame_base), 0);
    chk("rst_depth", 32'(frame_depth), 0);
    chk("rst_errs",  32'({err_overflow, err_underflow, err_param}), 0);
    chk("rst_pc",    32'(ret_pc_out), 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Basic call/return pair
    issue(1, 0, 2, 3, 'h40, 5, 0);
    issue(0, 1, 0, 0, 0, 10, 0);

    // Fill the 16-entry record store, one more overflows, then unwind
    for (int i = 0; i < 16; i++) issue(1, 0, 1, 1, 'h100 + i, 2 * i + 2, 0);
    issue(1, 0, 1, 1, 'h1FF, 40, 0);
    for (int i = 0; i < 16; i++) issue(0, 1, 0, 0, 0, 40, 0);

    // Underflow, then clear
    issue(0, 1, 0, 0, 0, 3, 0);
    err_clr = 1; @(posedge clk); #1; err_clr = 0;
    m_ovf = 0; m_und = 0; m_par = 0;
    chk("clr_errs", 32'({err_overflow, err_underflow, err_param}), 0);

    // Parameter errors
    issue(1, 1, 0, 0, 'h10, 5, 0);
    issue(1, 0, 6, 0, 'h11, 5, 0);

    // Operand-stack capacity boundary: exactly 256 fits, 257 does not
    issue(1, 0, 0, 57, 'h20, 200, 0);
    issue(1, 0, 0, 56, 'h21, 200, 0);
    issue(0, 1, 0, 0, 0, 0, 0);

    // err_clr with a simultaneous new error keeps the new flag
    issue(0, 1, 0, 0, 0, 0, 1);

    // Reset during EXEC of a call
    issue(1, 0, 1, 2, 'h77, 4, 0);
    call_req = 1; param_num = 1; local_num = 1; ret_pc_in = 16'h78; os_top_pointer = 9'd8;
    @(posedge clk); #1;
    call_req = 0;
    chk("pre_rst_call", 32'(os_call), 1);
    rst_n = 0; #1;
    model_reset();
    chk("mid_rst_call",  32'(os_call), 0);
    chk("mid_rst_shift", 32'(os_shift_vld), 0);
    chk("mid_rst_done",  32'(done), 0);
    chk("mid_rst_depth", 32'(frame_depth), 0);
    chk("mid_rst_base",  32'(frame_base), 0);
    chk("mid_rst_errs",  32'({err_overflow, err_underflow, err_param}), 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    issue(1, 0, 2, 3, 'h40, 5, 0);
    issue(0, 1, 0, 0, 0, 10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
